// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared frame layout, receiver states and frame builder for the inter-board key link
package link_pkg;

  localparam logic [1:0] LINK_MARKER = 2'b10;
  localparam int SPACE_BIT = 0;
  localparam int ENTER_BIT = 1;
  localparam int SEQ_LSB   = 2;
  localparam int SEQ_MSB   = 5;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  function automatic logic [7:0] build_frame(input logic [3:0] seq, input logic enter,
                                             input logic space);
    return {LINK_MARKER, seq, enter, space};
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 2-FF synchroniser and 8N1 receiver; flags good and framing-error stop bits
module uart_rx_core
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic            sync1;
  logic            rxs;
  rx_state_t       state;
  rx_state_t       state_next;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            bit_end;
  logic            data_sample;
  logic            cnt_clr;

  assign bit_end = (cnt == BIT_LAST);

  always_comb begin
    state_next  = state;
    data_sample = 1'b0;
    cnt_clr     = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rxs) state_next = START;
      end
      START: begin
        // A start bit that is gone by mid-bit was line noise: drop it silently.
        if (cnt == HALF_LAST) begin
          cnt_clr    = 1'b1;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_clr     = 1'b1;
          data_sample = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_clr    = 1'b1;
          state_next = rxs ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_clr = 1'b1;
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rxs     <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
      state <= state_next;
      cnt   <= cnt_clr ? '0 : cnt + CW'(1);
      if (state == IDLE) begin
        bit_idx <= '0;
      end else if (data_sample) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= {rxs, shreg[7:1]};
      end
    end
  end

  assign rx_byte   = shreg;
  assign byte_ok   = (state == STOP) && bit_end && rxs;
  assign frame_err = (state == STOP) && bit_end && !rxs;

endmodule

// File: rtl/link_rx.sv
// rtl/link_rx.sv - decodes remote key frames into levels/edges with sequence, timeout and error tracking
module link_rx
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564,
  parameter int TIMEOUT_CYC  = 650000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic       space_remote,
  output logic       enter_remote,
  output logic       space_rise,
  output logic       enter_rise,
  output logic       frame_valid,
  output logic       seq_gap,
  output logic       link_ok,
  output logic [7:0] err_count
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [7:0]    rx_byte;
  logic          byte_ok;
  logic          frame_err;
  logic [3:0]    seq;
  logic [3:0]    last_seq;
  logic          seq_valid;
  logic [TW-1:0] to_cnt;
  logic          marker_ok;
  logic          accept;
  logic          reject;
  logic          timed_out;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .rx_byte   (rx_byte),
    .byte_ok   (byte_ok),
    .frame_err (frame_err)
  );

  assign seq       = rx_byte[SEQ_MSB:SEQ_LSB];
  assign marker_ok = (rx_byte[7:6] == LINK_MARKER);
  assign accept    = byte_ok && marker_ok;
  assign reject    = frame_err || (byte_ok && !marker_ok);
  assign timed_out = !accept && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      space_remote <= 1'b0;
      enter_remote <= 1'b0;
      space_rise   <= 1'b0;
      enter_rise   <= 1'b0;
      frame_valid  <= 1'b0;
      seq_gap      <= 1'b0;
      link_ok      <= 1'b0;
      err_count    <= '0;
      last_seq     <= '0;
      seq_valid    <= 1'b0;
      to_cnt       <= '0;
    end else begin
      frame_valid <= 1'b0;
      space_rise  <= 1'b0;
      enter_rise  <= 1'b0;
      seq_gap     <= 1'b0;
      if (reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (accept) begin
        frame_valid  <= 1'b1;
        space_remote <= rx_byte[SPACE_BIT];
        enter_remote <= rx_byte[ENTER_BIT];
        space_rise   <= rx_byte[SPACE_BIT] & ~space_remote;
        enter_rise   <= rx_byte[ENTER_BIT] & ~enter_remote;
        seq_gap      <= seq_valid && (seq != last_seq + 4'd1);
        last_seq     <= seq;
        seq_valid    <= 1'b1;
        link_ok      <= 1'b1;
        to_cnt       <= '0;
      end else if (timed_out) begin
        // Levels drop without pulses so a lost link never looks like a key press.
        link_ok      <= 1'b0;
        space_remote <= 1'b0;
        enter_remote <= 1'b0;
        seq_valid    <= 1'b0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_link_rx.sv
// tb/tb_link_rx.sv - vector table plus frame scoreboard for link_rx
module tb_link_rx;
  import link_pkg::*;

  localparam int CPB = 16;
  localparam int TO  = 2000;
  localparam int NV  = 21;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic       space_remote;
  logic       enter_remote;
  logic       space_rise;
  logic       enter_rise;
  logic       frame_valid;
  logic       seq_gap;
  logic       link_ok;
  logic [7:0] err_count;

  link_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_in        (rx_in),
    .space_remote (space_remote),
    .enter_remote (enter_remote),
    .space_rise   (space_rise),
    .enter_rise   (enter_rise),
    .frame_valid  (frame_valid),
    .seq_gap      (seq_gap),
    .link_ok      (link_ok),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sp;
    logic en;
    logic sr;
    logic er;
    logic gap;
    logic link;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         low_bits;
    logic       valid;
    exp_t       e;
    logic [7:0] err;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[NV];
  int   passed = 0;
  int   total  = 0;

  function automatic void check1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endfunction

  function automatic void check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic exp_t mk_exp(input logic sp, input logic en, input logic sr,
                                  input logic er, input logic gap);
    exp_t e;
    e.sp = sp; e.en = en; e.sr = sr; e.er = er; e.gap = gap; e.link = 1'b1;
    return e;
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic stop, input int low,
                              input logic valid, input exp_t e, input logic [7:0] err);
    vec_t v;
    v.data = d; v.stop = stop; v.low_bits = low; v.valid = valid; v.e = e; v.err = err;
    return v;
  endfunction

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int low_bits);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    for (int i = 0; i < low_bits; i++) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  // Scoreboard: every frame_valid pops one expected record; pulses outside a frame are errors.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_frame: got frame_valid=1 expected no frame");
        end else begin
          e = exp_q.pop_front();
          check1("sb_space_remote", space_remote, e.sp);
          check1("sb_enter_remote", enter_remote, e.en);
          check1("sb_space_rise",   space_rise,   e.sr);
          check1("sb_enter_rise",   enter_rise,   e.er);
          check1("sb_seq_gap",      seq_gap,      e.gap);
          check1("sb_link_ok",      link_ok,      e.link);
        end
      end else if (space_rise || enter_rise || seq_gap) begin
        total++;
        $display("FAIL stray_pulse: got rise/gap=%b%b%b expected 000 without frame_valid",
                 space_rise, enter_rise, seq_gap);
      end
    end
  end

  initial begin
    vecs[0] = mk(build_frame(4'd0, 1'b0, 1'b1), 1'b1, 0, 1'b1, mk_exp(1, 0, 1, 0, 0), 8'd0);
    for (int k = 1; k < 16; k++)
      vecs[k] = mk(build_frame(4'(k), k[0], 1'b1), 1'b1, 0, 1'b1,
                   mk_exp(1'b1, k[0], 1'b0, k[0], 1'b0), 8'd0);
    vecs[16] = mk(build_frame(4'd0, 1'b0, 1'b1), 1'b1, 0, 1'b1, mk_exp(1, 0, 0, 0, 0), 8'd0);
    vecs[17] = mk(build_frame(4'd2, 1'b1, 1'b0), 1'b1, 0, 1'b1, mk_exp(0, 1, 0, 1, 1), 8'd0);
    vecs[18] = mk(8'h83, 1'b0, 3, 1'b0, mk_exp(0, 1, 0, 0, 0), 8'd1);
    vecs[19] = mk(build_frame(4'd3, 1'b1, 1'b1), 1'b1, 0, 1'b1, mk_exp(1, 1, 1, 0, 0), 8'd1);
    vecs[20] = mk(8'h43, 1'b1, 0, 1'b0, mk_exp(1, 1, 0, 0, 0), 8'd2);

    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check1("rst_space_remote", space_remote, 1'b0);
    check1("rst_link_ok",      link_ok,      1'b0);
    check1("rst_frame_valid",  frame_valid,  1'b0);
    check8("rst_err_count",    err_count,    8'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].valid) exp_q.push_back(vecs[i].e);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].low_bits);
      check1($sformatf("v%0d_space_remote", i), space_remote, vecs[i].e.sp);
      check1($sformatf("v%0d_enter_remote", i), enter_remote, vecs[i].e.en);
      check1($sformatf("v%0d_link_ok", i),      link_ok,      vecs[i].e.link);
      check8($sformatf("v%0d_err_count", i),    err_count,    vecs[i].err);
    end
    check8("table_frames_outstanding", 8'(exp_q.size()), 8'd0);

    // Short low glitch on an idle line.
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    check8("glitch_err_count", err_count, 8'd2);

    // Link loss, then recovery with an out-of-order sequence number.
    repeat (TO + 100) @(negedge clk);
    check1("timeout_link_ok",      link_ok,      1'b0);
    check1("timeout_space_remote", space_remote, 1'b0);
    check1("timeout_enter_remote", enter_remote, 1'b0);
    exp_q.push_back(mk_exp(1, 0, 1, 0, 0));
    send_frame(build_frame(4'd9, 1'b0, 1'b1), 1'b1, 0);
    check1("recover_link_ok",      link_ok,      1'b1);
    check1("recover_space_remote", space_remote, 1'b1);
    check8("recover_frames_outstanding", 8'(exp_q.size()), 8'd0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) send_frame(8'h43, 1'b1, 0);
    check8("sat_err_count", err_count, 8'd255);

    // Asynchronous reset in the middle of the data bits.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("arst_space_remote", space_remote, 1'b0);
    check1("arst_enter_remote", enter_remote, 1'b0);
    check1("arst_space_rise",   space_rise,   1'b0);
    check1("arst_enter_rise",   enter_rise,   1'b0);
    check1("arst_frame_valid",  frame_valid,  1'b0);
    check1("arst_seq_gap",      seq_gap,      1'b0);
    check1("arst_link_ok",      link_ok,      1'b0);
    check8("arst_err_count",    err_count,    8'd0);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    exp_q.push_back(mk_exp(0, 1, 0, 1, 0));
    send_frame(build_frame(4'd5, 1'b1, 1'b0), 1'b1, 0);
    check8("post_rst_err_count",    err_count,    8'd0);
    check1("post_rst_enter_remote", enter_remote, 1'b1);
    check8("final_frames_outstanding", 8'(exp_q.size()), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/link_rx.md
Name: link_rx

Overview:
Receiving end of the inter-board key link. The remote board sends its SPACE/ENTER key state as framed serial bytes on one pin. This block deserialises, validates and decodes those frames into clean remote key levels and edge pulses for the game FSM and turn FSMs. It replaces the raw SPACE_RX/ENTER_RX level wires. It sits between the board input pin and the top-level space_remote/enter_remote nets, and adds link-loss detection and error counting.

Parameters:
CLKS_PER_BIT, 564, clock cycles per serial bit (65 MHz / 115200 baud, integer division)
TIMEOUT_CYC, 650000, cycles without a valid frame before the link is declared lost (10 ms at 65 MHz)

Ports:
clk  in  1  system clock (65 MHz)
rst_n  in  1  asynchronous active-low reset
rx_in  in  1  serial line from remote board, asynchronous, idle high
space_remote  out  1  decoded remote SPACE level
enter_remote  out  1  decoded remote ENTER level
space_rise  out  1  1-cycle pulse on remote SPACE 0->1
enter_rise  out  1  1-cycle pulse on remote ENTER 0->1
frame_valid  out  1  1-cycle pulse per accepted frame
seq_gap  out  1  1-cycle pulse when an accepted frame's sequence number is not last+1
link_ok  out  1  high while valid frames arrive within TIMEOUT_CYC
err_count  out  8  count of rejected frames, saturating at 255

Behaviour:
- Reset is asynchronous and active-low. Reset values: all outputs 0; FSM IDLE; synchroniser flops 1; timeout counter 0; seq_valid 0.
- rx_in passes through a 2-FF synchroniser. All logic uses the synchronised bit, rxs.
- Frame format: 8N1, LSB first. Data byte = {2'b10 marker [7:6], seq[5:2], enter[1], space[0]}.
- FSM states:
  - IDLE: on rxs=0, go to START and clear the bit counter.
  - START: wait CLKS_PER_BIT/2 cycles (integer), then sample. If the sample is 1, treat it as a glitch and return to IDLE with no error. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles and shift into shreg from the LSB side. After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample. If 0, it is a framing error: increment err_count and go to BREAK. If 1 with marker 2'b10, accept the frame and go to IDLE. If 1 with a bad marker, increment err_count and go to IDLE.
  - BREAK: wait for rxs=1, then go to IDLE.
- Acceptance happens on the cycle after the stop-bit sample (latency 1). On that cycle:
  - frame_valid=1.
  - space_remote and enter_remote are loaded from bits [0] and [1].
  - space_rise = new space & ~old space_remote; enter_rise likewise.
  - The timeout counter clears and link_ok is set to 1.
- Sequence check: when seq_valid=1 and seq != (last_seq+1) mod 16, pulse seq_gap on the accept cycle. The frame is still accepted. On every accept, last_seq<=seq and seq_valid<=1. The 4-bit arithmetic wraps, so 15 -> 0 is legal.
- Timeout: the counter increments each cycle while not accepting. On reaching TIMEOUT_CYC-1:
  - link_ok<=0, space_remote<=0, enter_remote<=0, seq_valid<=0.
  - No rise pulses are generated.
  - The counter holds until the next accepted frame.
- The first accepted frame after link loss does not raise seq_gap. It does generate a rise pulse for any key bit that is 1.
- err_count saturates at 255 and never wraps. An error and a timeout on the same cycle are both applied independently.
- A new start edge during BREAK is ignored until the line returns high.
- Reset mid-frame discards the partial frame. No error is counted for it.

Decomposition:
- Package link_pkg holds:
  - LINK_MARKER=2'b10
  - field position constants (SPACE_BIT=0, ENTER_BIT=1, SEQ_LSB=2, SEQ_MSB=5)
  - typedef enum rx_state_t {IDLE, START, DATA, STOP, BREAK}
  - function build_frame(seq, enter, space), shared with the future link_tx and the bench
- One sub-module, uart_rx_core: synchroniser plus the 8N1 FSM. It outputs byte, byte_ok and frame_err. The decode, sequence and timeout logic stays in link_rx.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_CYC=2000):
- Reset then a single frame 0x81 (marker, seq=0, space=1): frame_valid=1 once; space_rise=1 once; space_remote=1; enter_remote=0; link_ok=1; seq_gap=0.
- Frames seq 1..15 then 0: no seq_gap. Then a frame with seq=2 (skipping 1): seq_gap pulses once and the frame is still accepted.
- Stop bit driven 0 on frame 0x83: err_count=1; outputs unchanged. A following valid frame is accepted only after the line returns high.
- Byte 0x43 (marker 2'b01): err_count increments; no frame_valid. A 5-cycle low glitch on an idle line: no error and no frame.
- Hold the line idle 2000 cycles after space=1 was accepted: link_ok=0 and space_remote=0 with no pulse. The next valid frame with space=1 sets link_ok=1 and space_rise=1, with no seq_gap.
- 300 bad-marker frames: err_count stops at 255. Assert rst_n=0 mid-DATA: all outputs are 0 immediately, asynchronously.
